fifo_byte_packer: RTL and testbench

FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

---
 rtl/fifo_pkg.sv | 18 +
 rtl/pack_timer.sv | 29 ++
 rtl/fifo_byte_packer.sv | 112 +++++++++++
 tb/tb_fifo_byte_packer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared FSM encoding and default sizing for the packer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam int c_PACK_NUM_DEFAULT = 4;
  localparam int c_TIMEOUT_DEFAULT  = 16;

endpackage
`default_nettype wire

// File: rtl/pack_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pack_timer : idle-cycle counter with terminal-count compare          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pack_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= 8'd0;
    end else if (inc) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = (r_count == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/fifo_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_byte_packer : packs PACK_NUM FIFO entries into one output word, |
// | flushing a partial word after TIMEOUT idle cycles. Rev 1.0           |
// +----------------------------------------------------------------------+
module fifo_byte_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_NUM   = fifo_pkg::c_PACK_NUM_DEFAULT,
  parameter int TIMEOUT    = fifo_pkg::c_TIMEOUT_DEFAULT
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  input  logic                           rd_valid,
  input  logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*PACK_NUM-1:0] out_data,
  output logic [3:0]                     out_bytes
);
  import fifo_pkg::*;

  localparam int c_ACC_W = DATA_WIDTH * PACK_NUM;

  state_t             r_state;
  state_t             w_next;
  logic [c_ACC_W-1:0] r_acc;
  logic [3:0]         r_cnt;
  logic               r_out_valid;
  logic [c_ACC_W-1:0] r_out_data;
  logic [3:0]         r_out_bytes;

  logic w_accept;
  logic w_full;
  logic w_expired;
  logic w_timeout;
  logic w_load;
  logic w_tmr_clr;
  logic w_tmr_inc;

  assign rd_ready  = !rd_rst && (r_state != ST_XFER);
  assign w_accept  = rd_valid && rd_ready;
  assign w_full    = w_accept && (r_cnt == 4'(PACK_NUM - 1));
  // An entry arriving in the expiry cycle takes priority over the flush.
  assign w_timeout = (r_state == ST_FILL) && w_expired && !w_accept;
  assign w_load    = (r_state == ST_XFER) && (!r_out_valid || out_ready);

  assign w_tmr_clr = w_accept || (r_state != ST_FILL);
  assign w_tmr_inc = (r_state == ST_FILL) && !w_accept;

  pack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .clr     (w_tmr_clr),
    .inc     (w_tmr_inc),
    .expired (w_expired)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_FILL;
      ST_FILL: if (w_full || w_timeout) w_next = ST_XFER;
      ST_XFER: if (w_load) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_acc       <= '0;
      r_cnt       <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= 4'd0;
    end else if (w_load) begin
      r_out_data  <= r_acc;
      r_out_bytes <= r_cnt;
      r_out_valid <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= 4'd0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_cnt <= r_cnt + 4'd1;
        for (int i = 0; i < PACK_NUM; i++) begin
          if (r_cnt == 4'(i)) begin
            r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bytes = r_out_bytes;

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_byte_packer : vector table plus corner sequences, scoreboard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fifo_byte_packer;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_bytes;

  logic        have;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  n;
  } exp_t;

  typedef struct {
    int          n;
    logic [7:0]  b[4];
    logic [31:0] exp_data;
    logic [3:0]  exp_bytes;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 rd_clk = ~rd_clk;

  // Source FIFO model: valid only while it has data and the packer requests.
  assign rd_valid = have & rd_ready;

  fifo_byte_packer #(
    .DATA_WIDTH (8),
    .PACK_NUM   (4),
    .TIMEOUT    (16)
  ) dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [3:0] n);
    exp_t e;
    e.d = d;
    e.n = n;
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every handshake, checks hold stability.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_bytes;

  always @(negedge rd_clk) begin
    if (!rd_rst) begin
      if (prev_hold) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_data", {32'd0, out_data}, {32'd0, prev_data});
        check("hold_bytes", {60'd0, out_bytes}, {60'd0, prev_bytes});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%08h/%0d, required no word", out_data, out_bytes);
        end else begin
          check("word_data", {32'd0, out_data}, {32'd0, sb[0].d});
          check("word_bytes", {60'd0, out_bytes}, {60'd0, sb[0].n});
          void'(sb.pop_front());
        end
      end
      prev_hold  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bytes = out_bytes;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int w;
    w       = 0;
    rd_data = b;
    have    = 1'b1;
    @(negedge rd_clk);
    while (!rd_ready && w < 100) begin
      @(negedge rd_clk);
      w++;
    end
    if (!rd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rd_ready_wait: got rd_ready=0 for 100 cycles, required 1");
    end
    @(posedge rd_clk);
    #1;
    have = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int w;
    w = 0;
    while (sb.size() != 0 && w < max_cyc) begin
      @(posedge rd_clk);
      w++;
    end
    #1;
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(posedge rd_clk);
    #1;
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{n: 4, b: '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, exp_data: 32'hEFBEADDE, exp_bytes: 4'd4};
    vecs[1] = '{n: 2, b: '{8'hA1, 8'hB2, 8'h00, 8'h00}, exp_data: 32'h0000B2A1, exp_bytes: 4'd2};
    vecs[2] = '{n: 1, b: '{8'h5A, 8'h00, 8'h00, 8'h00}, exp_data: 32'h0000005A, exp_bytes: 4'd1};
    vecs[3] = '{n: 3, b: '{8'h01, 8'h02, 8'h03, 8'h00}, exp_data: 32'h00030201, exp_bytes: 4'd3};
    vecs[4] = '{n: 4, b: '{8'h80, 8'h7F, 8'h00, 8'hFF}, exp_data: 32'hFF007F80, exp_bytes: 4'd4};

    rd_rst    = 1'b1;
    have      = 1'b0;
    rd_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1;
    check("reset_rd_ready", {63'd0, rd_ready}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", {32'd0, out_data}, 64'd0);
    check("reset_out_bytes", {60'd0, out_bytes}, 64'd0);
    rd_rst = 1'b0;
    step();
    check("idle_rd_ready", {63'd0, rd_ready}, 64'd1);

    // Full pack with two-cycle latency from the final accept.
    sb.push_back(mk(32'h44332211, 4'd4));
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    check("lat_n1_valid", {63'd0, out_valid}, 64'd0);
    check("xfer_rd_ready", {63'd0, rd_ready}, 64'd0);
    step();
    check("lat_n2_valid", {63'd0, out_valid}, 64'd1);
    check("lat_n2_data", {32'd0, out_data}, 64'h44332211);
    check("lat_n2_bytes", {60'd0, out_bytes}, 64'd4);
    drain(16);

    // Timeout flush lands exactly after the 16th idle cycle.
    sb.push_back(mk(32'h0000B2A1, 4'd2));
    push_byte(8'hA1);
    push_byte(8'hB2);
    repeat (16) @(posedge rd_clk);
    #1;
    check("tmo_early_valid", {63'd0, out_valid}, 64'd0);
    step();
    check("tmo_valid", {63'd0, out_valid}, 64'd1);
    check("tmo_data", {32'd0, out_data}, 64'h0000B2A1);
    drain(16);

    // Entry arriving in the expiry cycle suppresses the flush.
    sb.push_back(mk(32'h0000C3A1, 4'd2));
    push_byte(8'hA1);
    repeat (15) @(posedge rd_clk);
    #1;
    push_byte(8'hC3);
    for (int k = 0; k < 3; k++) begin
      check("contend_no_flush", {63'd0, out_valid}, 64'd0);
      step();
    end
    drain(64);

    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(vecs[i].exp_data, vecs[i].exp_bytes));
      for (int j = 0; j < vecs[i].n; j++) push_byte(vecs[i].b[j]);
      drain(64);
    end

    // Backpressure: second word waits in XFER, then follows with no bubble.
    sb.push_back(mk(32'h04030201, 4'd4));
    sb.push_back(mk(32'h08070605, 4'd4));
    out_ready = 1'b0;
    fork
      begin
        for (int j = 1; j <= 8; j++) push_byte(8'(j));
      end
      begin
        repeat (20) @(posedge rd_clk);
        #1;
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_data", {32'd0, out_data}, 64'h04030201);
        check("bp_rd_ready", {63'd0, rd_ready}, 64'd0);
        out_ready = 1'b1;
        step();
        check("bp_next_valid", {63'd0, out_valid}, 64'd1);
        check("bp_next_data", {32'd0, out_data}, 64'h08070605);
        step();
        check("bp_done_valid", {63'd0, out_valid}, 64'd0);
      end
    join
    drain(16);

    // Reset mid-fill discards the partial word.
    sb.push_back(mk(32'h88776655, 4'd4));
    push_byte(8'h99);
    push_byte(8'hAA);
    push_byte(8'hBB);
    rd_rst = 1'b1;
    #1;
    check("rst_rd_ready", {63'd0, rd_ready}, 64'd0);
    step();
    rd_rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_bytes", {60'd0, out_bytes}, 64'd0);
    push_byte(8'h55);
    push_byte(8'h66);
    push_byte(8'h77);
    push_byte(8'h88);
    drain(16);

    repeat (20) @(posedge rd_clk);
    #1;
    check("final_idle_valid", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
